// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state encodings and widths for the memory bus arbiter
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int LAT_CNT_W  = 3;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - master-side request/grant bus of the memory arbiter
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;

    modport master (output req, we, addr, wdata, input grant, ack, rdata);
    modport slave  (input req, we, addr, wdata, output grant, ack, rdata);
endinterface

// File: rtl/mem_bus_arbiter_rr_priority_picker.sv
// rtl/mem_bus_arbiter_rr_priority_picker.sv - round-robin winner search from a rotating pointer
module rr_priority_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);
    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        // first set bit at or above ptr, wrapping past N-1 back to 0
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one synchronous memory port among masters
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     owner;
    logic [LAT_CNT_W-1:0] lat_cnt;

    logic                 win_any;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [IDX_W-1:0]     win_idx;

    rr_priority_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (bus.req),
        .ptr    (rr_ptr),
        .any    (win_any),
        .onehot (win_onehot),
        .idx    (win_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bus.grant <= '0;
            bus.ack   <= '0;
            bus.rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            owner     <= '0;
            lat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    mem_we  <= 1'b0;
                    bus.ack <= '0;
                    if (win_any) begin
                        state     <= ST_ISSUE;
                        busy      <= 1'b1;
                        bus.grant <= win_onehot;
                        owner     <= win_idx;
                        mem_addr  <= bus.addr[win_idx*ADDR_W +: ADDR_W];
                        mem_wdata <= bus.wdata[win_idx*DATA_W +: DATA_W];
                        mem_we    <= bus.we[win_idx];
                        // writes complete as soon as the strobe is on the bus
                        bus.ack   <= bus.we[win_idx] ? win_onehot : '0;
                    end
                end
                ST_ISSUE: begin
                    mem_we  <= 1'b0;
                    bus.ack <= '0;
                    if (mem_we) begin
                        state <= ST_DONE;
                    end else begin
                        lat_cnt <= LAT_CNT_W'(READ_LAT - 1);
                        if (READ_LAT == 1) begin
                            bus.rdata <= mem_rdata;
                            bus.ack   <= bus.grant;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == LAT_CNT_W'(1)) begin
                        bus.rdata <= mem_rdata;
                        bus.ack   <= bus.grant;
                        state     <= ST_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    bus.ack   <= '0;
                    bus.grant <= '0;
                    busy      <= 1'b0;
                    rr_ptr    <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed and randomized checks of the memory bus arbiter
module tb_mem_bus_arbiter;

    typedef struct {
        int          m;
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        int          exp_lat;
        logic [15:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, rst_b, preload;
    logic [15:0] mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic [15:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic        mem_we_a, mem_we_b, busy_a, busy_b;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [15:0] ref_b [256];

    int checks = 0;
    int errors = 0;

    vec_t        vecs [8];
    int          lat;
    logic [15:0] rd;
    bit          gok;
    logic [15:0] a_seen;
    logic        we1, we2;
    logic [1:0]  prev_a;
    logic [1:0]  owners [4];
    int          ng, adj;
    logic [3:0]  ackv, nextg, gb, prev_gb;
    bit          pend [4];
    int          wg [4];
    int          oh_viol, ack_viol, acks, ai, npend;

    mem_bus_arbiter_if #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16)) bus_a ();
    mem_bus_arbiter_if #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(16)) bus_b ();

    mem_bus_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .READ_LAT(1)) u_dut_a (
        .clk       (clk),
        .reset     (rst_a),
        .bus       (bus_a),
        .mem_addr  (mem_addr_a),
        .mem_wdata (mem_wdata_a),
        .mem_we    (mem_we_a),
        .mem_rdata (mem_rdata_a),
        .busy      (busy_a)
    );

    mem_bus_arbiter #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(16), .READ_LAT(3)) u_dut_b (
        .clk       (clk),
        .reset     (rst_b),
        .bus       (bus_b),
        .mem_addr  (mem_addr_b),
        .mem_wdata (mem_wdata_b),
        .mem_we    (mem_we_b),
        .mem_rdata (mem_rdata_b),
        .busy      (busy_b)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        if (i == 32) return 16'h1234;
        return 16'(i * 257 + 16'h0F00);
    endfunction

    // address is held for the whole transaction, so a combinational read suits any latency
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= init_val(i);
                mem_b[i] <= init_val(i);
            end
        end else begin
            if (mem_we_a) mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
            if (mem_we_b) mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
        end
    end
    assign mem_rdata_a = mem_a[mem_addr_a[7:0]];
    assign mem_rdata_b = mem_b[mem_addr_b[7:0]];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drain_a();
        for (int c = 0; c < 12 && busy_a; c++) @(negedge clk);
    endtask

    task automatic drain_b();
        for (int c = 0; c < 12 && busy_b; c++) @(negedge clk);
    endtask

    task automatic run_a(input int m, input bit w, input logic [15:0] a, input logic [15:0] d,
                         output int l, output logic [15:0] r, output bit g_ok,
                         output logic [15:0] as, output logic w1, output logic w2);
        logic [1:0] mine;
        mine = 2'(2'b01 << m);
        l = 0; r = '0; g_ok = 1'b1; as = '0; w1 = 1'b0; w2 = 1'b0;
        @(negedge clk);
        bus_a.req = '0;
        bus_a.req[m] = 1'b1;
        bus_a.we[m] = w;
        bus_a.addr[m*16 +: 16] = a;
        bus_a.wdata[m*16 +: 16] = d;
        for (int c = 1; c <= 12 && l == 0; c++) begin
            @(negedge clk);
            if (bus_a.grant !== mine) g_ok = 1'b0;
            if (c == 1) begin as = mem_addr_a; w1 = mem_we_a; end
            if (bus_a.ack !== 2'b00) begin
                l = c;
                r = bus_a.rdata;
                if (bus_a.ack !== mine) g_ok = 1'b0;
                bus_a.req[m] = 1'b0;
            end
        end
        bus_a.req[m] = 1'b0;
        for (int c = 0; c < 12 && busy_a; c++) begin
            @(negedge clk);
            if (c == 0) w2 = mem_we_a;
            if (busy_a && bus_a.grant !== mine) g_ok = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        vecs[0] = '{0, 1'b1, 16'h0010, 16'hBEEF, 1, 16'h0000};
        vecs[1] = '{0, 1'b0, 16'h0010, 16'h0000, 2, 16'hBEEF};
        vecs[2] = '{1, 1'b0, 16'h0020, 16'h0000, 2, 16'h1234};
        vecs[3] = '{1, 1'b1, 16'h0030, 16'hCAFE, 1, 16'h0000};
        vecs[4] = '{0, 1'b0, 16'h0030, 16'h0000, 2, 16'hCAFE};
        vecs[5] = '{1, 1'b1, 16'h00FF, 16'h0001, 1, 16'h0000};
        vecs[6] = '{1, 1'b0, 16'h00FF, 16'h0000, 2, 16'h0001};
        vecs[7] = '{0, 1'b0, 16'h0005, 16'h0000, 2, 16'h1405};

        bus_a.req = '0; bus_a.we = '0; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = '0; bus_b.we = '0; bus_b.addr = '0; bus_b.wdata = '0;
        rst_a = 1'b1; rst_b = 1'b1; preload = 1'b1;
        for (int i = 0; i < 256; i++) ref_b[i] = init_val(i);
        repeat (3) @(negedge clk);

        check("rst_grant_a", bus_a.grant, 0);
        check("rst_ack_a", bus_a.ack, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_we_a", mem_we_a, 0);
        check("rst_addr_a", mem_addr_a, 0);
        check("rst_rdata_a", bus_a.rdata, 0);
        check("rst_grant_b", bus_b.grant, 0);
        check("rst_busy_b", busy_b, 0);
        preload = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_a(vecs[v].m, vecs[v].w, vecs[v].a, vecs[v].d, lat, rd, gok, a_seen, we1, we2);
            check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("v%0d_grant_held", v), gok, 1);
            check($sformatf("v%0d_mem_addr", v), a_seen, vecs[v].a);
            check($sformatf("v%0d_mem_we_issue", v), we1, vecs[v].w);
            if (vecs[v].w) check($sformatf("v%0d_mem_we_done", v), we2, 0);
            else check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
            check($sformatf("v%0d_idle_grant", v), bus_a.grant, 0);
        end

        // reset during the ISSUE cycle of a write; last owner was master 0 so rr_ptr was 1
        @(negedge clk);
        bus_a.req = 2'b01; bus_a.we = 2'b01;
        bus_a.addr[15:0] = 16'h0050; bus_a.wdata[15:0] = 16'h7777;
        @(negedge clk);
        check("t5_issue_we", mem_we_a, 1);
        rst_a = 1'b1;
        @(negedge clk);
        check("t5_ack", bus_a.ack, 0);
        check("t5_mem_we", mem_we_a, 0);
        check("t5_grant", bus_a.grant, 0);
        check("t5_busy", busy_a, 0);
        rst_a = 1'b0; bus_a.req = 2'b11; bus_a.we = 2'b00;
        @(negedge clk);
        check("t5_rr_ptr_reset", bus_a.grant, 2'b01);
        bus_a.req = 2'b00;
        drain_a();
        check("t5_idle", busy_a, 0);

        // both masters requesting continuously out of reset
        rst_a = 1'b1; bus_a.req = 2'b11; bus_a.we = 2'b11;
        bus_a.addr = {16'h0041, 16'h0040};
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        ng = 0; adj = 0; prev_a = 2'b00;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus_a.grant != 2'b00 && prev_a == 2'b00 && ng < 4) begin
                owners[ng] = bus_a.grant;
                ng++;
            end
            if (bus_a.grant != 2'b00 && prev_a != 2'b00 && bus_a.grant != prev_a) adj++;
            if (bus_a.grant == 2'b11) adj++;
            prev_a = bus_a.grant;
        end
        bus_a.req = 2'b00;
        drain_a();
        check("t3_grant_count", ng, 4);
        check("t3_owner0", owners[0], 2'b01);
        check("t3_owner1", owners[1], 2'b10);
        check("t3_owner2", owners[2], 2'b01);
        check("t3_owner3", owners[3], 2'b10);
        check("t3_no_adjacent", adj, 0);

        // READ_LAT=3 read by master 1
        @(negedge clk);
        bus_b.req = 4'b0010; bus_b.we = 4'b0000; bus_b.addr[31:16] = 16'h0020;
        lat = 0; rd = '0; ackv = '0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge clk);
            if (bus_b.ack != 4'b0000) begin
                lat = c; rd = bus_b.rdata; ackv = bus_b.ack; bus_b.req = 4'b0000;
            end
        end
        bus_b.req = 4'b0000;
        drain_b();
        check("t2_lat3_latency", lat, 4);
        check("t2_lat3_rdata", rd, 16'h1234);
        check("t2_lat3_ack", ackv, 4'b0010);

        // master 1 abandons its read during WAIT; master 0 is next
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        bus_b.req = 4'b0010; bus_b.addr[31:16] = 16'h0021; bus_b.addr[15:0] = 16'h0005;
        lat = 0; rd = '0; ackv = '0; nextg = '0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 2) bus_b.req = 4'b0001;
            if (bus_b.ack != 4'b0000) begin
                lat = c; rd = bus_b.rdata; ackv = bus_b.ack;
            end
        end
        for (int c = 0; c < 12 && nextg == 4'b0000; c++) begin
            @(negedge clk);
            if (bus_b.grant != 4'b0000 && bus_b.grant != 4'b0010) nextg = bus_b.grant;
        end
        bus_b.req = 4'b0000;
        drain_b();
        check("t4_latency", lat, 4);
        check("t4_ack", ackv, 4'b0010);
        check("t4_rdata", rd, 16'h3021);
        check("t4_next_grant", nextg, 4'b0001);

        // randomized traffic on four masters against a reference memory
        prev_gb = '0; oh_viol = 0; ack_viol = 0; acks = 0;
        for (int i = 0; i < 4; i++) begin pend[i] = 1'b0; wg[i] = 0; end
        for (int cyc = 0; cyc < 10300; cyc++) begin
            @(negedge clk);
            gb = bus_b.grant;
            if ((gb & (gb - 4'd1)) != 4'd0) oh_viol++;
            if ((bus_b.ack & ~gb) != 4'd0) ack_viol++;
            if (prev_gb == 4'd0 && gb != 4'd0)
                for (int j = 0; j < 4; j++) if (pend[j]) wg[j]++;
            for (int i = 0; i < 4; i++) begin
                if (bus_b.ack[i]) begin
                    if (!pend[i]) ack_viol++;
                    else begin
                        ai = int'(bus_b.addr[i*16 +: 8]);
                        if (bus_b.we[i]) ref_b[ai] = bus_b.wdata[i*16 +: 16];
                        else check("rand_rdata", bus_b.rdata, ref_b[ai]);
                        check("rand_starve", wg[i] <= 4, 1);
                        pend[i] = 1'b0; bus_b.req[i] = 1'b0; acks++;
                    end
                end else if (!pend[i] && cyc < 10000 && $urandom_range(3) == 0) begin
                    pend[i] = 1'b1; wg[i] = 0;
                    bus_b.req[i] = 1'b1;
                    bus_b.we[i] = 1'($urandom_range(1));
                    bus_b.addr[i*16 +: 16] = 16'($urandom_range(15));
                    bus_b.wdata[i*16 +: 16] = 16'($urandom);
                end
            end
            prev_gb = gb;
        end
        npend = 0;
        for (int i = 0; i < 4; i++) if (pend[i]) npend++;
        check("rand_onehot", oh_viol, 0);
        check("rand_ack_owner", ack_viol, 0);
        check("rand_progress", acks >= 1000, 1);
        check("rand_all_acked", npend, 0);
        check("rand_idle", busy_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
